// File: rtl/insn_encoder_if.sv
// Request/response bus of the RV32I instruction encoder.
// The master drives requests and accepts words; the slave is the encoder.
interface insn_encoder_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [DWIDTH-1:0] imm;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] insn;
  logic              err;

  modport master (
    output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, insn, err
  );

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, insn, err
  );
endinterface

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: packs opcode, register fields and a 32-bit
// immediate into an instruction word through a 2-stage valid/ready pipeline,
// counting output handshakes.
// Optional feature macro: IENC_RANGE_CHECK_EN -- flags out-of-range immediates
// and unknown opcodes; flagged requests emit a NOP with err set.
module insn_encoder #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  insn_encoder_if.slave        bus,
  output logic [CNT_WIDTH-1:0] enc_count_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [DWIDTH-1:0] NOP_WORD = DWIDTH'(32'h0000_0013);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6
  } fmt_e;

  typedef struct packed {
    fmt_e              fmt;
    logic [6:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [DWIDTH-1:0] imm;
    logic              err;
  } s1_t;

  logic                 s1_v_q, s1_v_d;
  s1_t                  s1_q, s1_d;
  logic                 s2_v_q, s2_v_d;
  logic [DWIDTH-1:0]    insn_q, insn_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  fmt_e                 fmt_c;
  logic                 err_c;
  s1_t                  req_c;
  logic [DWIDTH-1:0]    word_c;
  logic                 s2_ready_c;
  logic                 s1_ready_c;

  // A stage can load when empty or when its contents leave this cycle.
  assign s2_ready_c = !s2_v_q || bus.out_ready;
  assign s1_ready_c = !s1_v_q || s2_ready_c;

  assign bus.in_ready  = s1_ready_c;
  assign bus.out_valid = s2_v_q;
  assign bus.insn      = insn_q;
  assign bus.err       = err_q;
  assign enc_count_o   = cnt_q;

  // Classify the incoming request into an encoding format.
  always_comb begin
    fmt_c = FMT_R;
    case (bus.opcode)
      OP_LUI, OP_AUIPC:  fmt_c = FMT_U;
      OP_JAL:            fmt_c = FMT_J;
      OP_JALR, OP_LOAD:  fmt_c = FMT_I;
      OP_IMM:            fmt_c = (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) ? FMT_ISH : FMT_I;
      OP_BRANCH:         fmt_c = FMT_B;
      OP_STORE:          fmt_c = FMT_S;
      default:           fmt_c = FMT_R;
    endcase
  end

`ifdef IENC_RANGE_CHECK_EN
  // Flag immediates that do not fit their field and opcodes we cannot encode.
  always_comb begin
    err_c = 1'b0;
    case (fmt_c)
      FMT_I, FMT_S: err_c = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
      FMT_B:        err_c = !((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0];
      FMT_J:        err_c = !((&bus.imm[31:20]) || !(|bus.imm[31:20])) || bus.imm[0];
      FMT_U:        err_c = |bus.imm[11:0];
      FMT_ISH:      err_c = |bus.imm[31:5];
      default:      err_c = 1'b0;
    endcase
    if (!(bus.opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                             OP_LOAD, OP_STORE, OP_IMM, OP_OP})) begin
      err_c = 1'b1;
    end
  end
`else
  assign err_c = 1'b0;
`endif

  // Bundle the request for stage 1.
  always_comb begin
    req_c     = '0;
    req_c.fmt = fmt_c;
    req_c.op  = bus.opcode;
    req_c.rd  = bus.rd;
    req_c.rs1 = bus.rs1;
    req_c.rs2 = bus.rs2;
    req_c.f3  = bus.funct3;
    req_c.f7  = bus.funct7;
    req_c.imm = bus.imm;
    req_c.err = err_c;
  end

  // Assemble the instruction word from the stage-1 contents.
  always_comb begin
    word_c = {s1_q.f7, s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
    case (s1_q.fmt)
      FMT_U:   word_c = {s1_q.imm[31:12], s1_q.rd, s1_q.op};
      FMT_J:   word_c = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                         s1_q.rd, s1_q.op};
      FMT_I:   word_c = {s1_q.imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
      FMT_ISH: word_c = {s1_q.f7, s1_q.imm[4:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
      FMT_B:   word_c = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.f3,
                         s1_q.imm[4:1], s1_q.imm[11], s1_q.op};
      FMT_S:   word_c = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.imm[4:0], s1_q.op};
      default: word_c = {s1_q.f7, s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
    endcase
    if (s1_q.err) begin
      word_c = NOP_WORD;
    end
  end

  // Next-state for both pipeline stages and the handshake counter.
  always_comb begin
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    s2_v_d = s2_v_q;
    insn_d = insn_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (s2_ready_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        insn_d = word_c;
        err_d  = s1_q.err;
      end
    end
    if (s1_ready_c) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d = req_c;
      end
    end
    if (s2_v_q && bus.out_ready) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
      s2_v_q <= 1'b0;
      insn_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_q   <= s1_d;
      s2_v_q <= s2_v_d;
      insn_q <= insn_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Directed self-checking bench for insn_encoder.
module tb_insn_encoder;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] enc_count;
  int            errors = 0;
  int            checks = 0;
  int unsigned   exp_cnt = 0;

  insn_encoder_if #(.DWIDTH(DW)) bus ();

  insn_encoder #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .enc_count_o (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive_req(input vec_t t);
    bus.opcode = t.op;
    bus.rd     = t.rd;
    bus.rs1    = t.rs1;
    bus.rs2    = t.rs2;
    bus.funct3 = t.f3;
    bus.funct7 = t.f7;
    bus.imm    = t.imm;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // One request through an otherwise idle pipe; returns observed word and latency flag.
  task automatic xact(input vec_t t, output logic [31:0] insn, output logic err,
                      output logic lat_ok);
    logic v1, v2, rdy;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive_req(t);
    #1 rdy = bus.in_ready;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    v1 = bus.out_valid;
    @(negedge clk);
    v2   = bus.out_valid;
    insn = bus.insn;
    err  = bus.err;
    lat_ok = rdy && !v1 && v2;
    @(posedge clk);
    if (v2) exp_cnt++;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_req('{"idle", 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0});
    rst_n = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.insn !== 32'd0) begin errors++; $display("FAIL reset_insn: got %h expected 00000000", bus.insn); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (enc_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 00000000", enc_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_formats();
    vec_t v [7];
    logic [31:0] insn;
    logic err, lat_ok;
    v[0] = '{"addi_neg1", OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    v[1] = '{"beq_8",     OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0008, 32'h0000_0463, 1'b0};
    v[2] = '{"jal_800",   OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    v[3] = '{"lui",       OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    v[4] = '{"sw",        OP_STORE,  5'd0, 5'd3, 5'd2, 3'd2, 7'h00, 32'h0000_07FC, 32'h7E21_AE23, 1'b0};
    v[5] = '{"sub",       OP_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0};
    v[6] = '{"srai",      OP_IMM,    5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'h0000_0003, 32'h4033_5293, 1'b0};
    for (int i = 0; i < 7; i++) begin
      xact(v[i], insn, err, lat_ok);
      checks++; if (insn !== v[i].exp) begin errors++; $display("FAIL fmt_%s_insn: got %h expected %h", v[i].name, insn, v[i].exp); end
      checks++; if (err !== v[i].exp_err) begin errors++; $display("FAIL fmt_%s_err: got %b expected %b", v[i].name, err, v[i].exp_err); end
      checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL fmt_%s_latency: got %b expected 1", v[i].name, lat_ok); end
    end
    @(negedge clk);
    checks++; if (enc_count !== CW'(exp_cnt)) begin errors++; $display("FAIL fmt_count: got %0d expected %0d", enc_count, exp_cnt); end
  endtask

  task automatic test_range();
    vec_t v [5];
    logic [31:0] insn;
    logic err, lat_ok;
    v[0] = '{"addi_2048",  OP_IMM,    5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0013, 1'b0};
    v[1] = '{"beq_odd",    OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0007, 32'h0000_0363, 1'b0};
    v[2] = '{"unknown_op", 7'h7F,     5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_00FF, 1'b0};
    v[3] = '{"srli_32",    OP_IMM,    5'd1, 5'd1, 5'd0, 3'd5, 7'h00, 32'h0000_0020, 32'h0000_D093, 1'b0};
    v[4] = '{"lui_low",    OP_LUI,    5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5678, 32'h1234_50B7, 1'b0};
`ifdef IENC_RANGE_CHECK_EN
    for (int i = 0; i < 5; i++) begin
      v[i].exp     = 32'h0000_0013;
      v[i].exp_err = 1'b1;
    end
`endif
    for (int i = 0; i < 5; i++) begin
      xact(v[i], insn, err, lat_ok);
      checks++; if (insn !== v[i].exp) begin errors++; $display("FAIL range_%s_insn: got %h expected %h", v[i].name, insn, v[i].exp); end
      checks++; if (err !== v[i].exp_err) begin errors++; $display("FAIL range_%s_err: got %b expected %b", v[i].name, err, v[i].exp_err); end
    end
    @(negedge clk);
    checks++; if (enc_count !== CW'(exp_cnt)) begin errors++; $display("FAIL range_count: got %0d expected %0d", enc_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    vec_t v [4];
    logic [31:0] got_w [4];
    int sent, got;
    logic saw_stall, stable_ok, prev_stall, hs_in;
    logic [31:0] prev_insn;
    v[0] = '{"b0", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 32'h0010_0093, 1'b0};
    v[1] = '{"b1", OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 32'h0020_0113, 1'b0};
    v[2] = '{"b2", OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 32'h0030_0193, 1'b0};
    v[3] = '{"b3", OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4, 32'h0040_0213, 1'b0};
    apply_reset();
    sent = 0; got = 0;
    saw_stall = 1'b0; stable_ok = 1'b1; prev_stall = 1'b0; prev_insn = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 2 && c <= 4);
      if (sent < 4) begin
        bus.in_valid = 1'b1;
        drive_req(v[sent]);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (prev_stall && bus.insn !== prev_insn) stable_ok = 1'b0;
      if (!bus.in_ready) saw_stall = 1'b1;
      hs_in = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        got_w[got] = bus.insn;
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_insn  = bus.insn;
      if (hs_in) sent++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL b2b_words_out: got %0d expected 4", got); end
    for (int i = 0; i < 4 && i < got; i++) begin
      checks++; if (got_w[i] !== v[i].exp) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, got_w[i], v[i].exp); end
    end
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_low: got %b expected 1", saw_stall); end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL b2b_stall_stable: got %b expected 1", stable_ok); end
    checks++; if (enc_count !== 32'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", enc_count); end
    exp_cnt = 4;
  endtask

  task automatic test_wrap();
    vec_t t;
    logic [31:0] insn;
    logic err, lat_ok;
    t = '{"wrap", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    @(negedge clk);
    force dut.cnt_q = {CW{1'b1}};
    #1;
    release dut.cnt_q;
    #1;
    checks++; if (enc_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", enc_count); end
    xact(t, insn, err, lat_ok);
    @(negedge clk);
    checks++; if (enc_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h expected 00000000", enc_count); end
    checks++; if (insn !== t.exp) begin errors++; $display("FAIL wrap_insn: got %h expected %h", insn, t.exp); end
  endtask

  task automatic test_reset_midstream();
    vec_t a, b, c;
    logic [31:0] insn;
    logic err, lat_ok;
    a = '{"m0", OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7, 32'h0070_0393, 1'b0};
    b = '{"m1", OP_IMM, 5'd8, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8, 32'h0080_0413, 1'b0};
    c = '{"m2", OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_req(a);
    @(negedge clk);
    drive_req(b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_ready: got %b expected 0", bus.in_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", bus.out_valid); end
    checks++; if (enc_count !== 32'd0) begin errors++; $display("FAIL mid_async_count: got %0d expected 0", enc_count); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    xact(c, insn, err, lat_ok);
    checks++; if (insn !== c.exp) begin errors++; $display("FAIL mid_after_insn: got %h expected %h", insn, c.exp); end
    checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL mid_after_latency: got %b expected 1", lat_ok); end
    @(negedge clk);
    checks++; if (enc_count !== 32'd1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", enc_count); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_range();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
